sram_initiator: RTL
===================

Name: sram_initiator

Overview:
- Synchronous master-side controller for the board's asynchronous single-port SRAM.
- Accepts one read or write request at a time from an internal client over a ready/valid handshake.
- Drives the SRAM's active-high we/oe, address and data-out/drive-enable, with programmable wait states and bus turnaround.
- Sits between the memory arbiter and the top-level tristate pad; the top level builds the inout data bus from sram_dout/sram_dout_en/sram_din.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 19, SRAM address width
RD_WAIT, 2, cycles oe held high per read (>=1)
WR_WAIT, 2, cycles we held high per write (>=1)
TURN, 1, idle cycles after a read before next access (>=0)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  client request valid
wr  in  1  1=write, 0=read; sampled with req
addr  in  ADDR_WIDTH  request address
wdata  in  DATA_WIDTH  write data
ready  out  1  controller idle; request accepted when req&&ready
rvalid  out  1  one-cycle pulse, rdata valid
rdata  out  DATA_WIDTH  registered read data
sram_addr  out  ADDR_WIDTH  SRAM address
sram_we  out  1  SRAM write enable, active high
sram_oe  out  1  SRAM output enable, active high
sram_dout  out  DATA_WIDTH  data driven to SRAM
sram_dout_en  out  1  pad drive enable for sram_dout
sram_din  in  DATA_WIDTH  data returned from SRAM

Behaviour:
- One clock (clk); reset asynchronous active-high. On reset, immediately: state IDLE, ready=1, rvalid=0, rdata=0, sram_addr=0, sram_we=0, sram_oe=0, sram_dout=0, sram_dout_en=0, counter=0.
- All outputs except ready are registered; ready = (state==IDLE).
- States: IDLE, RD, TA, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: on req&&ready, latch addr (and wdata if wr) into sram_addr/sram_dout. Go to RD if !wr, else WR_SETUP. req while !ready is ignored; the client holds req until accepted.
- Read accepted at cycle T:
  - RD for cycles T+1..T+RD_WAIT: sram_oe=1, sram_dout_en=0.
  - On the edge ending cycle T+RD_WAIT: rdata<=sram_din, rvalid=1 for cycle T+RD_WAIT+1 only.
  - Then TA for TURN cycles (oe=0), then IDLE. With TURN=0, go straight to IDLE at T+RD_WAIT+1.
  - Defaults: oe high T+1..T+2; rvalid and TA at T+3; ready at T+4.
- Write accepted at T:
  - WR_SETUP at T+1: dout_en=1, we=0.
  - WR_PULSE T+2..T+1+WR_WAIT: we=1, dout_en=1.
  - WR_HOLD T+2+WR_WAIT: we=0, dout_en=1.
  - IDLE at T+3+WR_WAIT with dout_en=0.
  - Defaults: ready again at T+5.
- Invariants, every cycle:
  - never sram_we && sram_oe;
  - never sram_oe && sram_dout_en;
  - sram_addr stable for the whole access;
  - sram_addr and sram_dout hold their last values in IDLE (not cleared).
- Back-to-back: a request presented in the first IDLE cycle is accepted in that cycle; no extra bubble beyond TA.
- Wait counter width = clog2(max(RD_WAIT,WR_WAIT,TURN)+1); counts down and reloads on state entry.
- Reset mid-access: access is dropped; no rvalid is produced; we/oe/dout_en fall in the same instant as reset.
- rvalid has no backpressure; the client must consume it in the pulse cycle.

Decomposition:
- Shared package sram_pkg: state enum encoding, SRAM_ADDR_WIDTH/SRAM_DATA_WIDTH board constants, the clog2 helper function.
- Single module, no sub-module; the wait counter is inline.
- Tristate pad instantiation stays at top level.

Test Plan:
- Reset released, idle 5 cycles -> ready=1, we=oe=dout_en=rvalid=0, sram_addr=0, rdata=0.
- Write addr=0x12345, wdata=0xA5 at T (defaults) -> dout_en=1 T+1..T+4, we=1 only T+2..T+3, sram_addr=0x12345 throughout, ready=1 at T+5. Behavioural SRAM model holds 0xA5.
- Read addr=0x12345 at T -> oe=1 T+1..T+2, rvalid pulse at T+3 with rdata=0xA5, ready at T+4.
- Read then immediate write to 0x00001 with 0x3C -> write accepted at first ready cycle; oe and dout_en never overlap. Checker asserts both invariants every cycle; a subsequent read returns 0x3C.
- Parameter sweep RD_WAIT=1, WR_WAIT=3, TURN=0 -> read rvalid at T+2 and ready at T+2; write we high exactly 3 cycles, ready at T+6.
- Assert reset during WR_PULSE of a write of 0xFF -> we drops immediately, no rvalid, ready=1 after release; SRAM model shows no write with we high for fewer than WR_WAIT cycles is treated as a completed write.

Source files
------------

// File: rtl/sram_pkg.sv
// Board-level SRAM constants, controller state encoding and elaboration-time helpers
// shared by the SRAM initiator.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 19;
  localparam int unsigned SRAM_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StTa,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_initiator.sv
// Master-side controller for an asynchronous single-port SRAM: one read or write at a
// time, programmable oe/we pulse widths and post-read bus turnaround.
module sram_initiator
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned WR_WAIT    = 2,
  parameter int unsigned TURN       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_dout_en,
  input  logic [DATA_WIDTH-1:0] sram_din
);

  localparam int unsigned CntW = clog2(max3(RD_WAIT, WR_WAIT, TURN) + 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  sram_we_q, sram_we_d;
  logic                  sram_oe_q, sram_oe_d;
  logic [DATA_WIDTH-1:0] sram_dout_q, sram_dout_d;
  logic                  sram_dout_en_q, sram_dout_en_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rvalid_d       = 1'b0;
    rdata_d        = rdata_q;
    sram_addr_d    = sram_addr_q;
    sram_we_d      = sram_we_q;
    sram_oe_d      = sram_oe_q;
    sram_dout_d    = sram_dout_q;
    sram_dout_en_d = sram_dout_en_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          sram_addr_d = addr;
          if (wr) begin
            sram_dout_d    = wdata;
            sram_dout_en_d = 1'b1;
            state_d        = StWrSetup;
          end else begin
            sram_oe_d = 1'b1;
            cnt_d     = CntW'(RD_WAIT - 1);
            state_d   = StRd;
          end
        end
      end
      StRd: begin
        if (cnt_q == '0) begin
          // Capture on the edge that ends the last oe cycle.
          rdata_d   = sram_din;
          rvalid_d  = 1'b1;
          sram_oe_d = 1'b0;
          if (TURN > 0) begin
            cnt_d   = CntW'(TURN - 1);
            state_d = StTa;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StTa: begin
        if (cnt_q == '0) state_d = StIdle;
        else cnt_d = cnt_q - CntW'(1);
      end
      StWrSetup: begin
        sram_we_d = 1'b1;
        cnt_d     = CntW'(WR_WAIT - 1);
        state_d   = StWrPulse;
      end
      StWrPulse: begin
        if (cnt_q == '0) begin
          sram_we_d = 1'b0;
          state_d   = StWrHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrHold: begin
        sram_dout_en_d = 1'b0;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      sram_addr_q    <= '0;
      sram_we_q      <= 1'b0;
      sram_oe_q      <= 1'b0;
      sram_dout_q    <= '0;
      sram_dout_en_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      sram_addr_q    <= sram_addr_d;
      sram_we_q      <= sram_we_d;
      sram_oe_q      <= sram_oe_d;
      sram_dout_q    <= sram_dout_d;
      sram_dout_en_q <= sram_dout_en_d;
    end
  end

  assign ready        = (state_q == StIdle);
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign sram_addr    = sram_addr_q;
  assign sram_we      = sram_we_q;
  assign sram_oe      = sram_oe_q;
  assign sram_dout    = sram_dout_q;
  assign sram_dout_en = sram_dout_en_q;

endmodule
